fmul_pipe: RTL and testbench

Parametrised, fully pipelined floating-point multiplier: the next-generation replacement for the fixed single-precision multiplier in the FPU datapath. It adds configurable exponent and mantissa widths, round-to-nearest-even, valid/ready flow control with backpressure, a caller tag carried alongside each operation, and exception flags. It sits between the FPU issue stage and the writeback arbiter.

---
 rtl/fmul_pipe.sv | 183 ++++++++++++++++++
 tb/tb_fmul_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier: round-to-nearest-even, tag passthrough, exception flags.
// Define FMUL_SPECIAL_EN to honour IEEE NaN/infinity operands; otherwise all-ones exponents are ordinary values.
module fmul_pipe #(
   parameter int EW   = 8,
   parameter int MW   = 23,
   parameter int TAGW = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [EW+MW:0]    x1,
   input  logic [EW+MW:0]    x2,
   input  logic [TAGW-1:0]   in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EW+MW:0]    y,
   output logic [TAGW-1:0]   out_tag,
   output logic [2:0]        out_flags
);

   localparam int SW = MW + 1;
   localparam int HL = SW / 2;
   localparam int HH = SW - HL;
   localparam int PW = 2 * SW;
   localparam int XW = EW + 2;
   localparam logic [XW-1:0] BIAS = XW'(2**(EW-1) - 1);
   localparam logic [XW-1:0] EMAX = XW'(2**EW - 1);

   // Handshake: a stage-wide advance enable en = ~out_valid | out_ready. An operand pair is
   // taken when in_valid & in_ready, a result leaves when out_valid & out_ready; with en low
   // every stage, valid bit included, holds its contents.
   logic en;
   logic v1, v2, v3;

   assign en        = ~v3 | out_ready;
   assign in_ready  = en;
   assign out_valid = v3;

   // ---------------- operand classification ----------------
   logic [EW-1:0] e1, e2;
   logic [MW-1:0] m1, m2;
   logic          z1, z2;
   logic [SW-1:0] sig1, sig2;
   logic          spec_nan_d, spec_inf_d;

   assign e1   = x1[EW+MW-1:MW];
   assign e2   = x2[EW+MW-1:MW];
   assign m1   = x1[MW-1:0];
   assign m2   = x2[MW-1:0];
   assign z1   = ~|e1;
   assign z2   = ~|e2;
   assign sig1 = {1'b1, m1};
   assign sig2 = {1'b1, m2};

`ifdef FMUL_SPECIAL_EN
   logic nan1, nan2, inf1, inf2;
   assign nan1       = (&e1) & (|m1);
   assign nan2       = (&e2) & (|m2);
   assign inf1       = (&e1) & ~(|m1);
   assign inf2       = (&e2) & ~(|m2);
   assign spec_nan_d = nan1 | nan2 | (inf1 & z2) | (inf2 & z1);
   assign spec_inf_d = (inf1 | inf2) & ~spec_nan_d;
`else
   assign spec_nan_d = 1'b0;
   assign spec_inf_d = 1'b0;
`endif

   // ---------------- S1: partial products ----------------
   logic [2*HL-1:0]  pp_ll;
   logic [HL+HH-1:0] pp_lh, pp_hl;
   logic [2*HH-1:0]  pp_hh;
   logic             s1_sign, s1_zero, s1_nan, s1_inf;
   logic [XW-1:0]    s1_esum;
   logic [TAGW-1:0]  s1_tag;

   always_ff @(posedge clk) begin
      if (en && in_valid) begin
         pp_ll   <= (2*HL)'(sig1[HL-1:0]) * (2*HL)'(sig2[HL-1:0]);
         pp_lh   <= (HL+HH)'(sig1[HL-1:0]) * (HL+HH)'(sig2[SW-1:HL]);
         pp_hl   <= (HL+HH)'(sig1[SW-1:HL]) * (HL+HH)'(sig2[HL-1:0]);
         pp_hh   <= (2*HH)'(sig1[SW-1:HL]) * (2*HH)'(sig2[SW-1:HL]);
         s1_sign <= x1[EW+MW] ^ x2[EW+MW];
         s1_esum <= XW'(e1) + XW'(e2);
         s1_tag  <= in_tag;
         s1_zero <= z1 | z2;
         s1_nan  <= spec_nan_d;
         s1_inf  <= spec_inf_d;
      end
   end

   // ---------------- S2: sum, normalise, guard/sticky ----------------
   logic [PW-1:0] prod;
   logic          norm;
   logic [MW-1:0] frac_d;
   logic          guard_d, sticky_d;
   logic [XW-1:0] exp_d;

   assign prod     = (PW'(pp_hh) << (2*HL)) + (PW'(pp_lh) << HL) + (PW'(pp_hl) << HL) + PW'(pp_ll);
   assign norm     = prod[PW-1];
   assign frac_d   = norm ? prod[PW-2 -: MW] : prod[PW-3 -: MW];
   assign guard_d  = norm ? prod[SW-1] : prod[SW-2];
   assign sticky_d = norm ? |prod[SW-2:0] : |prod[SW-3:0];
   assign exp_d    = s1_esum - BIAS + XW'(norm);

   logic            s2_sign, s2_zero, s2_nan, s2_inf, s2_guard, s2_sticky;
   logic [XW-1:0]   s2_exp;
   logic [MW-1:0]   s2_frac;
   logic [TAGW-1:0] s2_tag;

   always_ff @(posedge clk) begin
      if (en && v1) begin
         s2_sign   <= s1_sign;
         s2_zero   <= s1_zero;
         s2_nan    <= s1_nan;
         s2_inf    <= s1_inf;
         s2_exp    <= exp_d;
         s2_frac   <= frac_d;
         s2_guard  <= guard_d;
         s2_sticky <= sticky_d;
         s2_tag    <= s1_tag;
      end
   end

   // ---------------- S3: round, range check, output register ----------------
   // The hidden bit is always 1 after S2, so only the stored fraction is rounded;
   // a carry out of it means the significand became 2.0.
   logic          inc, carry, inexact, uflow, oflow;
   logic [MW:0]   frac_sum;
   logic [XW-1:0] exp_r;
   logic [EW+MW:0] y_d;
   logic [2:0]    flags_d;

   assign inc      = s2_guard & (s2_sticky | s2_frac[0]);
   assign frac_sum = {1'b0, s2_frac} + (MW+1)'(inc);
   assign carry    = frac_sum[MW];
   assign exp_r    = s2_exp + XW'(carry);
   assign inexact  = s2_guard | s2_sticky;
   assign uflow    = exp_r[XW-1] | (exp_r == '0);
   assign oflow    = ~exp_r[XW-1] & (exp_r >= EMAX);

   always_comb begin
      y_d     = {s2_sign, exp_r[EW-1:0], frac_sum[MW-1:0]};
      flags_d = {2'b00, inexact};
      if (s2_nan) begin
         y_d     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
         flags_d = 3'b000;
      end else if (s2_inf) begin
         y_d     = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
         flags_d = 3'b000;
      end else if (s2_zero) begin
         y_d     = {s2_sign, {(EW+MW){1'b0}}};
         flags_d = 3'b000;
      end else if (uflow) begin
         y_d     = {s2_sign, {(EW+MW){1'b0}}};
         flags_d = 3'b011;
      end else if (oflow) begin
         y_d     = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
         flags_d = 3'b101;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         y         <= '0;
         out_tag   <= '0;
         out_flags <= '0;
      end else if (en) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         if (v2) begin
            y         <= y_d;
            out_tag   <= s2_tag;
            out_flags <= flags_d;
         end
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe (EW=8, MW=23): constant vectors, latency, backpressure,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_fmul_pipe;

   localparam int W  = 32;
   localparam int PW = W + 4 + 3;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   x1 = '0, x2 = '0;
   logic [3:0]     in_tag = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   y;
   logic [3:0]     out_tag;
   logic [2:0]     out_flags;

   fmul_pipe #(.EW(8), .MW(23), .TAGW(4)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .x2(x2), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .out_tag(out_tag), .out_flags(out_flags)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int             checks = 0;
   int             errors = 0;
   int             n_out = 0;
   logic [PW-1:0]  exp_q[$];
   logic [PW-1:0]  mon_e;
   bit             done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got y=%h tag=%h, required no output", y, out_tag);
         end else begin
            mon_e = exp_q.pop_front();
            check("result{y,tag,flags}", {25'b0, y, out_tag, out_flags}, {25'b0, mon_e});
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [PW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] tag);
      logic   s;
      int     ea, eb, e, sh;
      longint p, q, rem, half;
      logic   inex;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
`ifdef FMUL_SPECIAL_EN
      begin
         bit na, nb, ia, ib;
         na = (ea == 255) && (a[22:0] != 0);
         nb = (eb == 255) && (b[22:0] != 0);
         ia = (ea == 255) && (a[22:0] == 0);
         ib = (eb == 255) && (b[22:0] == 0);
         if (na || nb || (ia && eb == 0) || (ib && ea == 0))
            return {32'h7FC00000, tag, 3'b000};
         if (ia || ib)
            return {s, 8'hFF, 23'h0, tag, 3'b000};
      end
`endif
      if (ea == 0 || eb == 0) return {s, 31'h0, tag, 3'b000};
      p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e = ea + eb - 127;
      sh = 23;
      if (p >= (longint'(1) << 47)) begin
         sh = 24;
         e++;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
         q = q >> 1;
         e++;
      end
      inex = (rem != 0);
      if (e <= 0)   return {s, 31'h0, tag, 3'b011};
      if (e >= 255) return {s, 8'hFF, 23'h0, tag, 3'b101};
      return {s, e[7:0], q[22:0], tag, 2'b00, inex};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0] e;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      e = 8'h00;
      else if (r == 1) e = 8'($urandom_range(0, 255));
      else             e = 8'($urandom_range(100, 154));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic [PW-1:0] e);
      int n = 0;
      x1 = a;
      x2 = b;
      in_tag = tag;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 required 1 within 200 cycles");
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic [2:0]  f;
   } vec_t;

   vec_t vt[$];

   initial begin
      logic [31:0] ra, rb;
      int n0, n1;

      vt.push_back('{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000});
      vt.push_back('{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b001});
      vt.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b001});
      vt.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b101});
      vt.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 3'b011});
      vt.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000});
      vt.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000});
      vt.push_back('{32'hBF800000, 32'h40000000, 32'hC0000000, 3'b000});
`ifdef FMUL_SPECIAL_EN
      vt.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b000});
      vt.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000});
      vt.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000});
`else
      vt.push_back('{32'h7F800000, 32'h00000000, 32'h00000000, 3'b000});
      vt.push_back('{32'h7FC00000, 32'h3F800000, 32'h7F800000, 3'b101});
`endif

      // reset state
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_y", 64'(y), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_out_flags", 64'(out_flags), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      rstn = 1'b1;

      // latency: presented after edge N, result visible after edge N+3
      x1 = 32'h3FC00000;
      x2 = 32'h40000000;
      in_tag = 4'hA;
      in_valid = 1'b1;
      exp_q.push_back({32'h40400000, 4'hA, 3'b000});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_edge1_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("lat_edge2_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("lat_edge3_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;

      // table vectors, back to back
      foreach (vt[i]) send(vt[i].a, vt[i].b, 4'(i), {vt[i].y, 4'(i), vt[i].f});
      wait_drain();

      // backpressure: 6 ops, out_ready low for 5 cycles from the first result
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               ra = rand_op();
               rb = rand_op();
               send(ra, rb, 4'(i), model(ra, rb, 4'(i)));
            end
         end
         begin
            logic [W+6:0] held;
            int n = 0;
            while (!out_valid && n < 50) begin
               n++;
               @(posedge clk);
               #1;
            end
            check("bp_first_result_seen", 64'(out_valid), 64'd1);
            out_ready = 1'b0;
            held = {y, out_tag, out_flags};
            repeat (5) begin
               @(negedge clk);
               check("bp_in_ready_low", 64'(in_ready), 64'd0);
               check("bp_output_stable", 64'({y, out_tag, out_flags}), 64'(held));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();
      check("bp_result_count", 64'(n_out - n0), 64'd6);

      // reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         ra = rand_op();
         rb = rand_op();
         send(ra, rb, 4'(8 + i), model(ra, rb, 4'(8 + i)));
      end
      rstn = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_y", 64'(y), 64'd0);
      check("midrst_out_tag", 64'(out_tag), 64'd0);
      check("midrst_out_flags", 64'(out_flags), 64'd0);
      rstn = 1'b1;
      n1 = n_out;
      repeat (10) @(posedge clk);
      #1;
      check("midrst_no_stale", 64'(n_out - n1), 64'd0);

      // randomized traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               ra = rand_op();
               rb = rand_op();
               send(ra, rb, 4'(i), model(ra, rb, 4'(i)));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      repeat (5) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
